// File: rtl/program_launcher.sv
// Host-side launcher: queues program start addresses, pulses start to the processor,
// waits for a done rising edge (or timeout) and reports the run length.
module program_launcher #(
  parameter int ADDR_W       = 7,
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 1,
  parameter int CYC_W        = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_address,
  output logic              req_ready,
  output logic              start,
  output logic [ADDR_W-1:0] start_address,
  input  logic              done,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_address,
  output logic [CYC_W-1:0]  result_cycles,
  output logic              result_timeout,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LCH_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [LCH_W-1:0] LCH_LAST  = LCH_W'(START_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [LCH_W-1:0]  lch_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              done_q;
  logic              done_evt;
  logic              push;
  logic              pop;

  // Request handshake: an address transfers on a rising clock edge where
  // req_valid && req_ready; req_ready depends only on the registered fill level.
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign done_evt  = done && !done_q;
  assign fsm_state = state;

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= req_address;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done_q         <= 1'b1;
      lch_cnt        <= '0;
      cyc_cnt        <= '0;
      start          <= 1'b0;
      start_address  <= '0;
      result_valid   <= 1'b0;
      result_address <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
    end else begin
      done_q    <= done;
      count     <= count_nxt;
      req_ready <= (count_nxt < FULL_CNT);
      busy      <= pop || (state == S_LAUNCH) || (state == S_WAIT) || (count_nxt != '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          if (pop) begin
            start_address <= mem[rd_ptr];
            start         <= 1'b1;
            lch_cnt       <= '0;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (lch_cnt == LCH_LAST) begin
            start   <= 1'b0;
            cyc_cnt <= CYC_W'(1);
            state   <= S_WAIT;
          end else begin
            lch_cnt <= lch_cnt + LCH_W'(1);
          end
        end
        S_WAIT: begin
          // A completion on the timeout cycle still counts as a normal finish.
          if (done_evt) begin
            result_valid   <= 1'b1;
            result_address <= start_address;
            result_cycles  <= cyc_cnt;
            result_timeout <= 1'b0;
            state          <= S_REPORT;
          end else if (cyc_cnt == TIMEOUT_C) begin
            result_valid   <= 1'b1;
            result_address <= start_address;
            result_cycles  <= TIMEOUT_C;
            result_timeout <= 1'b1;
            state          <= S_REPORT;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        S_REPORT: begin
          result_valid <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
